// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if - core/decoder-side bus of the exception controller.
//   slave  : seen by exc_ctrl (takes decoder status, drives PC redirect/MRS data)
//   master : seen by the core/decoder side
// Signals:
//   EStatus/ERet/PC/SysRegSel          core -> controller
//   IrqToDec/ExcTaken/IrqAck           controller -> decoder/core
//   Redirect/RedirectPC                controller -> PC mux
//   SysRegData                         controller -> MRS read path
//   InHandler/DoubleFault              controller status
interface exc_ctrl_if #(
    parameter int N = 64
);
    logic          IrqToDec;
    logic [3:0]    EStatus;
    logic          ERet;
    logic [N-1:0]  PC;
    logic [1:0]    SysRegSel;
    logic [N-1:0]  SysRegData;
    logic          ExcTaken;
    logic          Redirect;
    logic [N-1:0]  RedirectPC;
    logic          IrqAck;
    logic          InHandler;
    logic          DoubleFault;

    modport slave (
        input  EStatus, ERet, PC, SysRegSel,
        output IrqToDec, SysRegData, ExcTaken, Redirect, RedirectPC,
               IrqAck, InHandler, DoubleFault
    );

    modport master (
        output EStatus, ERet, PC, SysRegSel,
        input  IrqToDec, SysRegData, ExcTaken, Redirect, RedirectPC,
               IrqAck, InHandler, DoubleFault
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl - exception/interrupt controller for the single-cycle core.
// Synchronises ExtIRQ, latches a rising edge as a pending IRQ and offers it to
// the decoder only while not in handler mode. On any exception reported by the
// decoder it records ELR/ESR, bumps a saturating exception counter, enters
// handler mode and redirects the PC to VECTOR. ERET in handler mode returns to
// ELR. A fault raised inside the handler sets the sticky DoubleFault bit.
// Ports:
//   clk     core clock
//   reset   asynchronous, active-low reset
//   ExtIRQ  raw asynchronous interrupt level
//   bus     exc_ctrl_if.slave (decoder status in, redirect / MRS data out)
module exc_ctrl #(
    parameter int            N           = 64,
    parameter logic [N-1:0]  VECTOR      = 'hD8,
    parameter int            SYNC_STAGES = 2,
    parameter int            CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ExtIRQ,
    exc_ctrl_if.slave   bus
);
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       elr_reg;
    logic [3:0]         esr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               df_reg;
    logic               pending_reg, pending_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_in;
    logic               edge_prev_reg;
    logic               irq_rise;

    logic               exc_taken;
    logic               irq_ack;
    logic               handler_fault;
    logic               handler_ret;
    logic               redirect;
    logic [N-1:0]       redirect_pc;

    // Synchroniser chain: stage 0 samples the raw pin, later stages follow.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_in[gi] = ExtIRQ;
            end else begin : g_rest
                assign sync_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg      <= '0;
            edge_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= sync_in;
            edge_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_reg[SYNC_STAGES-1] & ~edge_prev_reg;

    // A new edge wins over a simultaneous ack so that edge is not lost.
    assign pending_next = irq_rise | (pending_reg & ~irq_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. A fault in the handler keeps us there even with ERET.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL:  if (exc_taken)   state_next = HANDLER;
            HANDLER: if (handler_ret) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // FSM: outputs
    always_comb begin
        exc_taken     = 1'b0;
        handler_fault = 1'b0;
        handler_ret   = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = VECTOR;
        if (state_reg == NORMAL) begin
            exc_taken = (bus.EStatus != 4'b0000);
            redirect  = exc_taken;
        end else begin
            handler_fault = (bus.EStatus != 4'b0000);
            handler_ret   = bus.ERet & ~handler_fault;
            redirect      = handler_fault | handler_ret;
            if (handler_ret) begin
                redirect_pc = elr_reg;
            end
        end
    end

    assign irq_ack = exc_taken & (bus.EStatus == 4'b0001);

    // Exception record and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr_reg <= '0;
            esr_reg <= '0;
            cnt_reg <= '0;
            df_reg  <= 1'b0;
        end else begin
            if (exc_taken) begin
                elr_reg <= bus.PC;
                esr_reg <= bus.EStatus;
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            if (handler_fault) begin
                df_reg <= 1'b1;
            end
        end
    end

    // MRS read mux, zero-extended to the datapath width.
    always_comb begin
        bus.SysRegData = '0;
        case (bus.SysRegSel)
            2'b00:   bus.SysRegData = elr_reg;
            2'b01:   bus.SysRegData = N'(esr_reg);
            2'b10:   bus.SysRegData = N'(cnt_reg);
            default: bus.SysRegData = N'(state_reg == HANDLER);
        endcase
    end

    assign bus.IrqToDec    = pending_reg & (state_reg == NORMAL);
    assign bus.ExcTaken    = exc_taken;
    assign bus.IrqAck      = irq_ack;
    assign bus.Redirect    = redirect;
    assign bus.RedirectPC  = redirect_pc;
    assign bus.InHandler   = (state_reg == HANDLER);
    assign bus.DoubleFault = df_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
    localparam int          N   = 64;
    localparam logic [63:0] VEC = 64'hD8;
    localparam int          S   = 2;
    localparam int          CW  = 8;

    logic clk = 1'b0;
    logic reset;
    logic ExtIRQ;

    exc_ctrl_if #(.N(N)) bus ();

    exc_ctrl #(.N(N), .VECTOR(VEC), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .ExtIRQ (ExtIRQ),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] es, input logic er, input logic [63:0] pc, input logic [1:0] sel);
        bus.EStatus   = es;
        bus.ERet      = er;
        bus.PC        = pc;
        bus.SysRegSel = sel;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ExtIRQ = 1'b0;
        drive(4'd0, 1'b0, 64'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [3:0]  es;
        logic        eret;
        logic [63:0] pc;
        logic [1:0]  sel;
        logic        exc;
        logic        red;
        logic [63:0] rpc;
        logic        ack;
        logic [63:0] srd;
        logic        inh;
        logic        df;
    } vec_t;

    vec_t tbl[15];

    // Behavioural reference state for the random phase.
    bit          m_inh, m_df, m_pend;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;
    int          m_cnt;
    bit          hist[$];   // ExtIRQ samples at recent edges, newest first

    task automatic model_reset();
        m_inh = 0; m_df = 0; m_pend = 0; m_elr = '0; m_esr = '0; m_cnt = 0;
        hist = {};
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ExtIRQ = 1'b0;
        drive(4'd0, 1'b0, 64'd0, 2'd0);

        //            es    er   pc      sel  exc red rpc     ack srd     inh df
        tbl[0]  = '{4'd0, 1'b1, 64'h10, 2'd3, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0};
        tbl[1]  = '{4'd2, 1'b0, 64'h20, 2'd0, 1'b1, 1'b1, 64'hD8, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[2]  = '{4'd0, 1'b0, 64'hD8, 2'd0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h20, 1'b1, 1'b0};
        tbl[3]  = '{4'd0, 1'b0, 64'hDC, 2'd1, 1'b0, 1'b0, 64'h0,  1'b0, 64'h2,  1'b1, 1'b0};
        tbl[4]  = '{4'd0, 1'b0, 64'hE0, 2'd2, 1'b0, 1'b0, 64'h0,  1'b0, 64'h1,  1'b1, 1'b0};
        tbl[5]  = '{4'd0, 1'b0, 64'hE4, 2'd3, 1'b0, 1'b0, 64'h0,  1'b0, 64'h1,  1'b1, 1'b0};
        tbl[6]  = '{4'd0, 1'b1, 64'hE8, 2'd3, 1'b0, 1'b1, 64'h20, 1'b0, 64'h1,  1'b1, 1'b0};
        tbl[7]  = '{4'd0, 1'b0, 64'h20, 2'd3, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0};
        tbl[8]  = '{4'd2, 1'b1, 64'h24, 2'd0, 1'b1, 1'b1, 64'hD8, 1'b0, 64'h20, 1'b0, 1'b0};
        tbl[9]  = '{4'd2, 1'b1, 64'hD8, 2'd0, 1'b0, 1'b1, 64'hD8, 1'b0, 64'h24, 1'b1, 1'b0};
        tbl[10] = '{4'd0, 1'b0, 64'hDC, 2'd1, 1'b0, 1'b0, 64'h0,  1'b0, 64'h2,  1'b1, 1'b1};
        tbl[11] = '{4'd0, 1'b1, 64'hE0, 2'd2, 1'b0, 1'b1, 64'h24, 1'b0, 64'h2,  1'b1, 1'b1};
        tbl[12] = '{4'd1, 1'b0, 64'h28, 2'd3, 1'b1, 1'b1, 64'hD8, 1'b1, 64'h0,  1'b0, 1'b1};
        tbl[13] = '{4'd0, 1'b0, 64'hD8, 2'd1, 1'b0, 1'b0, 64'h0,  1'b0, 64'h1,  1'b1, 1'b1};
        tbl[14] = '{4'd0, 1'b0, 64'hDC, 2'd2, 1'b0, 1'b0, 64'h0,  1'b0, 64'h3,  1'b1, 1'b1};

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].es, tbl[i].eret, tbl[i].pc, tbl[i].sel);
            #1;
            $display("vec %0d es=%0d eret=%0b pc=%h sel=%0d red=%0b rpc=%h srd=%h",
                     i, tbl[i].es, tbl[i].eret, tbl[i].pc, tbl[i].sel,
                     bus.Redirect, bus.RedirectPC, bus.SysRegData);
            chk($sformatf("vec%0d ExcTaken", i), bus.ExcTaken, tbl[i].exc);
            chk($sformatf("vec%0d Redirect", i), bus.Redirect, tbl[i].red);
            if (tbl[i].red) chk($sformatf("vec%0d RedirectPC", i), bus.RedirectPC, tbl[i].rpc);
            chk($sformatf("vec%0d IrqAck", i), bus.IrqAck, tbl[i].ack);
            chk($sformatf("vec%0d SysRegData", i), bus.SysRegData, tbl[i].srd);
            chk($sformatf("vec%0d InHandler", i), bus.InHandler, tbl[i].inh);
            chk($sformatf("vec%0d DoubleFault", i), bus.DoubleFault, tbl[i].df);
            tick();
        end

        // ---------------- IRQ latency and return ----------------
        do_reset();
        ExtIRQ = 1'b1;
        for (int c = 1; c <= S + 1; c++) begin
            tick();
            $display("irq latency cycle %0d IrqToDec=%0b", c, bus.IrqToDec);
            chk($sformatf("irq lat c%0d", c), bus.IrqToDec, (c == S + 1) ? 1'b1 : 1'b0);
        end
        drive(4'd1, 1'b0, 64'h30, 2'd0);
        #1;
        $display("irq take pc=30 ack=%0b red=%0b", bus.IrqAck, bus.Redirect);
        chk("irq ExcTaken", bus.ExcTaken, 1'b1);
        chk("irq IrqAck", bus.IrqAck, 1'b1);
        chk("irq RedirectPC", bus.RedirectPC, VEC);
        tick();
        drive(4'd0, 1'b0, 64'hD8, 2'd0);
        #1;
        chk("irq ELR", bus.SysRegData, 64'h30);
        bus.SysRegSel = 2'd1;
        #1;
        chk("irq ESR", bus.SysRegData, 64'h1);
        bus.ERet = 1'b1;
        #1;
        $display("irq eret red=%0b rpc=%h", bus.Redirect, bus.RedirectPC);
        chk("irq eret Redirect", bus.Redirect, 1'b1);
        chk("irq eret RedirectPC", bus.RedirectPC, 64'h30);
        tick();
        drive(4'd0, 1'b0, 64'h30, 2'd3);
        #1;
        chk("irq pending cleared", bus.IrqToDec, 1'b0);
        chk("irq mode after eret", bus.SysRegData, 64'h0);

        // ---------------- IRQ arriving inside the handler ----------------
        ExtIRQ = 1'b0;
        repeat (S + 2) tick();
        drive(4'd2, 1'b0, 64'h50, 2'd0);
        tick();
        drive(4'd0, 1'b0, 64'hD8, 2'd0);
        ExtIRQ = 1'b1;
        for (int c = 0; c < S + 3; c++) begin
            tick();
            $display("masked irq cycle %0d IrqToDec=%0b", c, bus.IrqToDec);
            chk($sformatf("masked irq c%0d", c), bus.IrqToDec, 1'b0);
        end
        bus.ERet = 1'b1;
        #1;
        chk("masked eret RedirectPC", bus.RedirectPC, 64'h50);
        tick();
        drive(4'd0, 1'b0, 64'h50, 2'd0);
        #1;
        chk("held irq offered", bus.IrqToDec, 1'b1);
        bus.EStatus = 4'd1;
        #1;
        chk("held irq IrqAck", bus.IrqAck, 1'b1);
        tick();
        drive(4'd0, 1'b0, 64'hD8, 2'd0);
        #1;
        chk("held irq ELR", bus.SysRegData, 64'h50);

        // ---------------- async reset mid-handler ----------------
        do_reset();
        ExtIRQ = 1'b1;
        repeat (S + 1) tick();
        drive(4'd2, 1'b0, 64'h40, 2'd0);
        tick();
        drive(4'd0, 1'b0, 64'hD8, 2'd0);
        #1;
        chk("pre-reset InHandler", bus.InHandler, 1'b1);
        chk("pre-reset ELR", bus.SysRegData, 64'h40);
        #2;
        reset = 1'b0;
        ExtIRQ = 1'b0;
        #1;
        $display("async reset applied InHandler=%0b", bus.InHandler);
        chk("rst InHandler", bus.InHandler, 1'b0);
        chk("rst DoubleFault", bus.DoubleFault, 1'b0);
        chk("rst IrqToDec", bus.IrqToDec, 1'b0);
        chk("rst Redirect", bus.Redirect, 1'b0);
        for (int s = 0; s < 4; s++) begin
            bus.SysRegSel = 2'(s);
            #1;
            chk($sformatf("rst sysreg%0d", s), bus.SysRegData, 64'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < S + 3; c++) begin
            tick();
            chk($sformatf("pending lost c%0d", c), bus.IrqToDec, 1'b0);
        end

        // ---------------- counter saturation ----------------
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            drive(4'd2, 1'b0, 64'h100, 2'd2);
            tick();
            drive(4'd0, 1'b1, 64'hD8, 2'd2);
            tick();
            if (k == 254) chk("cnt 254", bus.SysRegData, 64'd254);
        end
        drive(4'd0, 1'b0, 64'h100, 2'd2);
        #1;
        $display("saturation ExcCount=%0d", bus.SysRegData);
        chk("cnt saturated", bus.SysRegData, 64'd255);
        bus.SysRegSel = 2'd3;
        #1;
        chk("cnt mode", bus.SysRegData, 64'd0);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        model_reset();
        for (int t = 0; t < 400; t++) begin
            logic [3:0]  es;
            logic        er;
            logic [63:0] pc;
            logic [1:0]  sel;
            int          r;
            bit          e_exc, e_ack, e_red, e_itd, rise;
            logic [63:0] e_rpc, e_srd;

            r = $urandom_range(0, 9);
            es = (r < 6) ? 4'd0 : (r < 8) ? 4'd1 : 4'd2;
            er = ($urandom_range(0, 9) < 3);
            pc = {$urandom, $urandom};
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ExtIRQ = ~ExtIRQ;
            drive(es, er, pc, sel);
            #1;

            e_exc = (es != 0) && !m_inh;
            e_ack = e_exc && (es == 4'd1);
            e_red = e_exc || (m_inh && (es != 0 || er));
            e_rpc = (m_inh && es == 0 && er) ? m_elr : VEC;
            e_itd = m_pend && !m_inh;
            case (sel)
                2'd0:    e_srd = m_elr;
                2'd1:    e_srd = 64'(m_esr);
                2'd2:    e_srd = 64'(m_cnt);
                default: e_srd = 64'(m_inh);
            endcase

            $display("rnd %0d es=%0d eret=%0b pc=%h sel=%0d irq=%0b red=%0b rpc=%h",
                     t, es, er, pc, sel, ExtIRQ, bus.Redirect, bus.RedirectPC);
            chk("rnd ExcTaken", bus.ExcTaken, e_exc);
            chk("rnd IrqAck", bus.IrqAck, e_ack);
            chk("rnd Redirect", bus.Redirect, e_red);
            if (e_red) chk("rnd RedirectPC", bus.RedirectPC, e_rpc);
            chk("rnd IrqToDec", bus.IrqToDec, e_itd);
            chk("rnd SysRegData", bus.SysRegData, e_srd);
            chk("rnd InHandler", bus.InHandler, m_inh);
            chk("rnd DoubleFault", bus.DoubleFault, m_df);

            // Architectural effect of this cycle.
            rise = hist[S-1] && !hist[S];
            if (e_exc) begin
                m_elr = pc;
                m_esr = es;
                m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
                m_inh = 1;
            end else if (m_inh && es != 0) begin
                m_df = 1;
            end else if (m_inh && er) begin
                m_inh = 0;
            end
            m_pend = rise ? 1'b1 : (e_ack ? 1'b0 : m_pend);

            @(posedge clk);
            hist.push_front(ExtIRQ);
            void'(hist.pop_back());
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
